// File: rtl/product_accumulator.sv
// Sums a batch of N_SAMPLES small unsigned products into a saturating 8-bit total
// and hands the result downstream over a valid/ready handshake.
module product_accumulator #(
  parameter int N_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_p,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       overflow,
  output logic [4:0] count
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_SAMPLES - 1);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic [4:0] cnt_q, cnt_d;
  logic [8:0] sum9;
  logic       accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid outputs come only from the state register, never from the partner signal.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;

  assign accept = in_valid && (state_q == ACCUM);
  assign sum9   = {1'b0, acc_q} + {5'b0_0000, in_p};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 5'd1;
      // Once at 255 any further product keeps the sum >= 255, so saturation holds.
      if (sum9[8]) begin
        acc_d = 8'hFF;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum9[7:0];
      end
      if (cnt_q == LAST_IDX) begin
        state_d = DONE;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = ACCUM;
      acc_d   = 8'd0;
      ovf_d   = 1'b0;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= 8'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001: Parameter N_SAMPLES, default 8, SHALL set the number of products accepted per batch; legal range 1..31.
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: in_valid  input  1  SHALL indicate that in_p carries a product from the upstream multiply stage.
REQ-005: in_p  input  4  SHALL carry an unsigned product; legal range 0..9, with 10..15 accepted as-is and never rejected.
REQ-006: in_ready  output  1  SHALL indicate the block accepts in_p this cycle.
REQ-007: out_valid  output  1  SHALL indicate that out_sum and overflow hold a completed batch result.
REQ-008: out_ready  input  1  SHALL indicate the downstream consumer accepts the result.
REQ-009: out_sum  output  8  SHALL carry the unsigned saturated batch sum.
REQ-010: overflow  output  1  SHALL flag a saturated batch; sticky for the batch.
REQ-011: count  output  5  SHALL give the number of products accepted in the current batch.

Function
REQ-012: The block SHALL implement a two-state FSM with states ACCUM and DONE.
REQ-013: In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014: In DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-015: An accept SHALL occur only when in_valid=1 and in_ready=1 at a rising clk edge; in_p SHALL be ignored otherwise.
REQ-016: On accept, the block SHALL zero-extend in_p to 9 bits and add it to the 8-bit accumulator.
REQ-017: On accept, if that 9-bit sum exceeds 255, the accumulator SHALL load 255 and overflow SHALL set; otherwise the accumulator SHALL load the sum.
REQ-018: Once overflow is set, it SHALL remain 1 until the batch result is consumed or reset asserts.
REQ-019: Once saturated, the accumulator SHALL remain at 255 on all further accepts in the batch.
REQ-020: On accept, count SHALL increment by 1.
REQ-021: On the accept where count=N_SAMPLES-1, the FSM SHALL move to DONE, and count SHALL read N_SAMPLES in DONE.
REQ-022: out_valid SHALL assert in the cycle immediately after the N_SAMPLES-th accept (latency 1 clk).
REQ-023: out_sum SHALL equal the accumulator, and be stable, throughout DONE.
REQ-024: In DONE, out_sum, overflow and count SHALL hold while out_ready=0; no products SHALL be accepted.
REQ-025: On a rising edge in DONE with out_ready=1, the block SHALL clear the accumulator, count and overflow and return to ACCUM; in_ready SHALL be 1 in the next cycle.
REQ-026: in_valid=1 in the same cycle as the DONE->ACCUM transition SHALL NOT be accepted, since in_ready=0 that cycle.
REQ-027: With N_SAMPLES=1, every accept SHALL move the FSM directly to DONE.
REQ-028: in_ready SHALL depend only on FSM state, with no combinational path from in_valid.
REQ-029: out_valid SHALL depend only on FSM state, with no combinational path from out_ready.

Reset
REQ-030: While reset=1 at a rising edge, the FSM SHALL enter ACCUM and clear the accumulator, count and overflow, overriding any accept or out_ready that cycle.
REQ-031: After reset, out_sum SHALL be 0, count 0, overflow 0, out_valid 0 and in_ready 1.
REQ-032: Reset asserted mid-batch or in DONE SHALL discard the partial or pending result, with no out_valid pulse.

Verification
REQ-033: N=8, feed 3,6,9,0,3,6,9,0 back-to-back with out_ready=1 -> out_valid=1 in cycle after 8th accept, out_sum=36, overflow=0, count=8.
REQ-034: N=20, 20 products of 15 -> out_sum=255 with overflow=1; the following batch of 20 products of 1 -> out_sum=20 with overflow=0.
REQ-035: N=8, batch complete with out_ready=0 for 5 cycles and in_valid=1 held -> in_ready=0, out_sum/count unchanged, no accepts; out_ready=1 -> ACCUM next cycle, count=0.
REQ-036: N=8, in_valid toggled 1,0,1,0,... with in_p=9 -> only valid cycles counted; out_sum=72 after 8 accepts.
REQ-037: N=8, reset=1 after 5 accepts of 9 -> next cycle count=0, out_sum=0, in_ready=1; a fresh 8 accepts of 1 -> out_sum=8.
REQ-038: N=1, in_p=7 accepted -> out_valid=1 next cycle with out_sum=7; simultaneous in_valid on the consume cycle is not accepted.
